// File: rtl/banked_reg_bank.sv
// Banked register file: 27 physical registers with USR/FIQ/IRQ/SVC views, a
// shared PC with load/increment, and a power-on clear sweep that raises busy.
//
// state | meaning
// CLEAR | sweeping zeros into physical registers 0..26, busy=1, ports ignored
// READY | normal operation
module banked_reg_bank #(
  parameter int DATA_W = 32,
  parameter int PC_INC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              user_bank,
  input  logic [3:0]        read_A_select,
  input  logic [3:0]        read_B_select,
  input  logic              read_B_en,
  input  logic [3:0]        write_select,
  input  logic              write_en,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_pc_en,
  input  logic [DATA_W-1:0] write_pc_data,
  input  logic              pc_inc_en,
  output logic [DATA_W-1:0] read_A_data,
  output logic [DATA_W-1:0] read_B_data,
  output logic [DATA_W-1:0] read_pc_data,
  output logic              busy
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int N_PHYS = 27;
  localparam logic [4:0] LAST_PHYS = 5'd26;
  localparam logic [4:0] PC_PHYS = 5'd15;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_b_q, rd_b_d;
  logic [DATA_W-1:0] regs_q [N_PHYS];
  logic [DATA_W-1:0] regs_d [N_PHYS];
  logic [4:0]        phys_a, phys_b, phys_w;

  // Physical layout: 0-15 USR, 16-22 FIQ R8-R14, 23-24 IRQ R13-R14, 25-26 SVC R13-R14.
  function automatic logic [4:0] map_phys(input logic [3:0] idx, input logic [1:0] m,
                                          input logic ub);
    logic [4:0] p;
    p = {1'b0, idx};
    if (!ub) begin
      case (m)
        2'b01:   if (idx >= 4'd8 && idx <= 4'd14) p = {1'b0, idx} + 5'd8;
        2'b10:   if (idx == 4'd13 || idx == 4'd14) p = {1'b0, idx} + 5'd10;
        2'b11:   if (idx == 4'd13 || idx == 4'd14) p = {1'b0, idx} + 5'd12;
        default: p = {1'b0, idx};
      endcase
    end
    return p;
  endfunction

  assign phys_a = map_phys(read_A_select, mode, user_bank);
  assign phys_b = map_phys(read_B_select, mode, user_bank);
  assign phys_w = map_phys(write_select, mode, user_bank);

  assign read_A_data  = regs_q[phys_a];
  assign read_pc_data = regs_q[PC_PHYS];
  assign read_B_data  = rd_b_q;
  assign busy         = (state_q == ST_CLEAR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_b_d  = rd_b_q;
    regs_d  = regs_q;
    if (state_q == ST_CLEAR) begin
      regs_d[cnt_q] = '0;
      if (cnt_q == LAST_PHYS) state_d = ST_READY;
      else                    cnt_d   = cnt_q + 5'd1;
    end else begin
      if (write_en && write_select != 4'd15) regs_d[phys_w] = write_data;
      // R15 has one winner per cycle: ALU write, then PC load, then increment.
      if (write_en && write_select == 4'd15) regs_d[PC_PHYS] = write_data;
      else if (write_pc_en)                  regs_d[PC_PHYS] = write_pc_data;
      else if (pc_inc_en)                    regs_d[PC_PHYS] = regs_q[PC_PHYS] + DATA_W'(PC_INC);
      if (read_B_en) begin
        if (write_en && phys_w == phys_b) rd_b_d = write_data;
        else                              rd_b_d = regs_q[phys_b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      rd_b_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_b_q  <= rd_b_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_banked_reg_bank.sv
// Randomized bench for banked_reg_bank against a per-bank array model, plus
// directed checks for clear timing, banking, port-B bypass and PC priority.
module tb_banked_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        user_bank;
  logic [3:0]  read_A_select, read_B_select, write_select;
  logic        read_B_en, write_en, write_pc_en, pc_inc_en;
  logic [31:0] write_data, write_pc_data;
  logic [31:0] read_A_data, read_B_data, read_pc_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: one array per bank, as the programmer sees it.
  logic [31:0] m_usr [16];
  logic [31:0] m_fiq [8];
  logic [31:0] m_irq [2];
  logic [31:0] m_svc [2];
  logic [31:0] m_rdb;

  banked_reg_bank #(.DATA_W(32), .PC_INC(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .user_bank(user_bank),
    .read_A_select(read_A_select), .read_B_select(read_B_select),
    .read_B_en(read_B_en), .write_select(write_select), .write_en(write_en),
    .write_data(write_data), .write_pc_en(write_pc_en),
    .write_pc_data(write_pc_data), .pc_inc_en(pc_inc_en),
    .read_A_data(read_A_data), .read_B_data(read_B_data),
    .read_pc_data(read_pc_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // 0 USR, 1 FIQ, 2 IRQ, 3 SVC: which bank a logical index lands in.
  function automatic int bank_of(input int idx, input int m, input bit ub);
    if (ub || m == 0) return 0;
    if (m == 1 && idx >= 8 && idx <= 14) return 1;
    if (m == 2 && (idx == 13 || idx == 14)) return 2;
    if (m == 3 && (idx == 13 || idx == 14)) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input int idx, input int m, input bit ub);
    case (bank_of(idx, m, ub))
      1:       return m_fiq[idx-8];
      2:       return m_irq[idx-13];
      3:       return m_svc[idx-13];
      default: return m_usr[idx];
    endcase
  endfunction

  task automatic m_write(input int idx, input int m, input bit ub, input logic [31:0] v);
    case (bank_of(idx, m, ub))
      1:       m_fiq[idx-8]  = v;
      2:       m_irq[idx-13] = v;
      3:       m_svc[idx-13] = v;
      default: m_usr[idx]    = v;
    endcase
  endtask

  task automatic m_zero();
    for (int i = 0; i < 16; i++) m_usr[i] = '0;
    for (int i = 0; i < 8; i++)  m_fiq[i] = '0;
    for (int i = 0; i < 2; i++) begin m_irq[i] = '0; m_svc[i] = '0; end
    m_rdb = '0;
  endtask

  task automatic idle();
    read_B_en = 0; write_en = 0; write_pc_en = 0; pc_inc_en = 0;
    write_data = '0; write_pc_data = '0; write_select = '0;
    read_A_select = '0; read_B_select = '0; user_bank = 0;
  endtask

  // One READY cycle: check combinational reads, predict, clock, check port B.
  task automatic step();
    logic [31:0] pc_next;
    int ka, kb, kw;
    #1;
    chk("rd_a", read_A_data, m_read(read_A_select, mode, user_bank));
    chk("rd_pc", read_pc_data, m_usr[15]);
    kb = bank_of(read_B_select, mode, user_bank) * 16 + int'(read_B_select);
    kw = bank_of(write_select, mode, user_bank) * 16 + int'(write_select);
    ka = 0;
    if (read_B_en)
      m_rdb = (write_en && kw == kb) ? write_data : m_read(read_B_select, mode, user_bank);
    pc_next = m_usr[15];
    if (write_en && write_select == 4'd15) pc_next = write_data;
    else if (write_pc_en)                  pc_next = write_pc_data;
    else if (pc_inc_en)                    pc_next = m_usr[15] + 32'd4;
    if (write_en && write_select != 4'd15) m_write(write_select, mode, user_bank, write_data);
    m_usr[15] = pc_next;
    @(posedge clk); #1;
    chk("rd_b", read_B_data, m_rdb);
    chk("busy_ready", {31'd0, busy}, 32'd0 + ka);
  endtask

  // Counts busy cycles starting from the sample after the current edge.
  task automatic count_busy(input bit hammer, output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (hammer) begin
        write_en = 1; write_pc_en = 1; pc_inc_en = 1; read_B_en = 1;
        write_select = 4'($urandom_range(0, 15)); read_B_select = 4'($urandom_range(0, 15));
        write_data = $urandom; write_pc_data = $urandom; mode = 2'($urandom);
      end
      @(posedge clk); #1;
    end
    idle();
  endtask

  task automatic check_all_zero();
    for (int m = 0; m < 4; m++)
      for (int i = 0; i < 16; i++) begin
        mode = 2'(m); read_A_select = 4'(i); #1;
        chk($sformatf("zero_m%0d_r%0d", m, i), read_A_data, 32'd0);
      end
    mode = 2'd0;
  endtask

  int nb;

  initial begin
    rst = 0; mode = 2'd0; idle();
    @(posedge clk); #1;

    // Reset and clear sweep
    rst = 1;
    @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_rdb", read_B_data, 32'd0);
    rst = 0;
    count_busy(0, nb);
    chk("busy_len", nb, 32'd27);
    m_zero();
    check_all_zero();

    // Banking
    mode = 2'd0; write_select = 4'd13; write_en = 1; write_data = 32'h11; step();
    mode = 2'd3; write_data = 32'h22; step();
    mode = 2'd1; write_select = 4'd8; write_data = 32'h33; step();
    idle();
    mode = 2'd0; read_A_select = 4'd13; #1; chk("usr_r13", read_A_data, 32'h11);
    read_A_select = 4'd8; #1; chk("usr_r8", read_A_data, 32'h0);
    mode = 2'd3; read_A_select = 4'd13; #1; chk("svc_r13", read_A_data, 32'h22);
    mode = 2'd1; read_A_select = 4'd8; #1; chk("fiq_r8", read_A_data, 32'h33);
    mode = 2'd3; user_bank = 1; read_A_select = 4'd13; #1; chk("svc_ub_r13", read_A_data, 32'h11);
    idle(); mode = 2'd0;

    // Port-B bypass then hold
    write_select = 4'd3; write_en = 1; write_data = 32'hAB;
    read_B_select = 4'd3; read_B_en = 1; step();
    chk("bypass", read_B_data, 32'hAB);
    read_B_en = 0; write_data = 32'hCD; step();
    chk("hold", read_B_data, 32'hAB);
    idle();

    // PC priority and wrap
    write_pc_en = 1; write_pc_data = 32'h100; step(); idle();
    chk("pc_load", read_pc_data, 32'h100);
    write_en = 1; write_select = 4'd15; write_data = 32'h200;
    write_pc_en = 1; write_pc_data = 32'h300; pc_inc_en = 1; step();
    chk("pc_alu_wins", read_pc_data, 32'h200);
    write_en = 0; step();
    chk("pc_load_wins", read_pc_data, 32'h300);
    write_pc_en = 0; step();
    chk("pc_inc", read_pc_data, 32'h304);
    idle();
    write_pc_en = 1; write_pc_data = 32'hFFFF_FFFC; step(); idle();
    pc_inc_en = 1; step(); idle();
    chk("pc_wrap", read_pc_data, 32'h0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      mode          = 2'($urandom);
      user_bank     = ($urandom_range(0, 3) == 0);
      read_A_select = 4'($urandom);
      read_B_select = 4'($urandom);
      write_select  = 4'($urandom);
      read_B_en     = 1'($urandom);
      write_en      = 1'($urandom);
      write_pc_en   = ($urandom_range(0, 7) == 0);
      pc_inc_en     = 1'($urandom);
      write_data    = $urandom;
      write_pc_data = $urandom;
      if ($urandom_range(0, 3) == 0) read_B_select = write_select;
      step();
    end
    idle();

    // Reset in the middle of the sweep, with traffic hammering during busy
    rst = 1; @(posedge clk); #1; rst = 0;
    for (int c = 0; c < 10; c++) begin
      write_en = 1; write_pc_en = 1; pc_inc_en = 1; read_B_en = 1;
      write_select = 4'($urandom); write_data = $urandom;
      @(posedge clk); #1;
    end
    idle();
    rst = 1; @(posedge clk); #1; rst = 0;
    count_busy(1, nb);
    chk("midclr_busy_len", nb, 32'd27);
    chk("midclr_rdb", read_B_data, 32'd0);
    m_zero();
    check_all_zero();
    chk("midclr_pc", read_pc_data, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
